// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: front-end command issuer for the ALU core.
// Synchronises and debounces the send button, snapshots the switches on each
// clean press, offers exactly one command per press over valid/ready, then
// waits for the core's response and latches the result byte for display.
//
// Ports:
//   clock, reset         board clock (rising edge), async active-high reset
//   sw[15:0]             switches: [15:8] data byte, [3:0] opcode
//   btn                  raw bouncy send button, asynchronous to clock
//   cmd_valid/op/data    command offered to the core
//   cmd_ready            core accepts the offered command this cycle
//   rsp_valid, rsp_y     core result handshake
//   result               last captured Y
//   busy                 a command is in flight
//   dropped              sticky: a press arrived while busy
module alu_cmd_issuer #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic        cmd_valid,
  output logic [3:0]  cmd_op,
  output logic [7:0]  cmd_data,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_y,
  output logic [7:0]  result,
  output logic        busy,
  output logic        dropped
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Opcodes above this one manipulate A/B only and produce no displayable Y.
  localparam logic [3:0] LAST_RESULT_OP = 4'hC;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t           state_q, state_d;
  logic             btn_s1, btn_s2;
  logic [15:0]      sw_s1, sw_s2;
  logic             deb_q, deb_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press;

  logic             cmd_valid_d;
  logic [3:0]       cmd_op_d;
  logic [7:0]       cmd_data_d;
  logic [7:0]       result_d;
  logic             dropped_d;
  logic             capture;
  logic             sw_unused;

  assign sw_unused = ^sw_s2[7:4];

  // Two-flop synchronisers for the button and switches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
    end else begin
      deb_dly_q <= deb_q;
      if (btn_s2 == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        deb_q <= ~deb_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press = deb_q & ~deb_dly_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a same-edge accept+response skips WAIT_RSP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (press)     state_d = ISSUE;
      ISSUE:    if (cmd_ready) state_d = rsp_valid ? IDLE : WAIT_RSP;
      WAIT_RSP: if (rsp_valid) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    cmd_valid_d = cmd_valid;
    cmd_op_d    = cmd_op;
    cmd_data_d  = cmd_data;
    result_d    = result;
    dropped_d   = dropped | (press & (state_q != IDLE));
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = sw_s2[3:0];
          cmd_data_d  = sw_s2[15:8];
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          capture     = rsp_valid;
        end
      end
      WAIT_RSP: capture = rsp_valid;
      default: ;
    endcase
    if (capture && (cmd_op <= LAST_RESULT_OP)) result_d = rsp_y;
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_data  <= '0;
      result    <= '0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      cmd_valid <= cmd_valid_d;
      cmd_op    <= cmd_op_d;
      cmd_data  <= cmd_data_d;
      result    <= result_d;
      busy      <= (state_d != IDLE);
      dropped   <= dropped_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed bench for alu_cmd_issuer with DEBOUNCE_CYCLES=4.
// A transaction-level model tracks the expected outputs; a negedge process
// compares every cycle, and the stimulus adds hand-computed literal checks.
module tb_alu_cmd_issuer;

  localparam int unsigned D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic        btn = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_y = 8'h00;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [7:0]  result;
  logic        busy;
  logic        dropped;

  int n_checks = 0;
  int n_fail   = 0;

  alu_cmd_issuer #(.DEBOUNCE_CYCLES(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .sw        (sw),
    .btn       (btn),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .result    (result),
    .busy      (busy),
    .dropped   (dropped)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: button history window, press flag, outstanding command.
  logic         m_s1 = 1'b0, m_s2 = 1'b0;
  logic [15:0]  m_sw1 = '0, m_sw2 = '0;
  logic [D-1:0] m_hist = '0;
  logic         m_deb = 1'b0, m_press = 1'b0;
  logic         m_valid = 1'b0, m_busy = 1'b0, m_accepted = 1'b0, m_dropped = 1'b0;
  logic [3:0]   m_op = '0;
  logic [7:0]   m_data = '0, m_result = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_sw1 = '0; m_sw2 = '0; m_hist = '0;
      m_deb = 1'b0; m_press = 1'b0;
      m_valid = 1'b0; m_busy = 1'b0; m_accepted = 1'b0; m_dropped = 1'b0;
      m_op = '0; m_data = '0; m_result = '0;
    end else begin
      if (m_busy) begin
        if (m_press) m_dropped = 1'b1;
        if (m_valid && cmd_ready) begin
          m_valid = 1'b0;
          m_accepted = 1'b1;
        end
        if (m_accepted && rsp_valid) begin
          if (int'(m_op) <= 12) m_result = rsp_y;
          m_accepted = 1'b0;
          m_busy = 1'b0;
        end
      end else if (m_press) begin
        m_busy = 1'b1;
        m_valid = 1'b1;
        m_op = m_sw2[3:0];
        m_data = m_sw2[15:8];
      end
      // Level flips once the last D synced samples all disagree with it.
      m_press = 1'b0;
      m_hist = {m_hist[D-2:0], m_s2};
      if (m_hist == {D{~m_deb}}) begin
        m_deb = ~m_deb;
        m_press = m_deb;
      end
      m_s2 = m_s1; m_s1 = btn;
      m_sw2 = m_sw1; m_sw1 = sw;
    end
  end

  always @(negedge clock) begin
    check("cmd_valid", 16'(cmd_valid), 16'(m_valid));
    check("busy", 16'(busy), 16'(m_busy));
    check("dropped", 16'(dropped), 16'(m_dropped));
    check("result", 16'(result), 16'(m_result));
    if (m_valid) begin
      check("cmd_op", 16'(cmd_op), 16'(m_op));
      check("cmd_data", 16'(cmd_data), 16'(m_data));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 16'(cmd_valid), 16'h0);
    check({tag, "_busy"}, 16'(busy), 16'h0);
    check({tag, "_result"}, 16'(result), 16'h0);
    check({tag, "_dropped"}, 16'(dropped), 16'h0);
  endtask

  initial begin
    // Reset with a toggling button, then release with the button low.
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      btn = ~btn;
      cycles(1);
      check_zero("rst_hold");
    end
    reset = 1'b0;
    btn = 1'b0;
    cycles(3);
    check_zero("rst_after");

    // Bounce rejection: 2-cycle pulses never satisfy the debounce window.
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      cycles(2);
      check("bounce_valid", 16'(cmd_valid), 16'h0);
    end
    btn = 1'b0;
    cycles(8);
    check("bounce_busy", 16'(busy), 16'h0);

    // Backpressure: command held stable while switches change.
    sw = 16'h0F07; btn = 1'b1; cmd_ready = 1'b0;
    cycles(6);
    check("bp_valid_e6", 16'(cmd_valid), 16'h0);
    cycles(1);
    check("bp_valid_e7", 16'(cmd_valid), 16'h1);
    sw = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      check("bp_hold_valid", 16'(cmd_valid), 16'h1);
      check("bp_hold_op", 16'(cmd_op), 16'h7);
      check("bp_hold_data", 16'(cmd_data), 16'h0F);
    end
    cmd_ready = 1'b1;
    cycles(1);
    check("bp_xfer_valid", 16'(cmd_valid), 16'h0);
    check("bp_xfer_busy", 16'(busy), 16'h1);
    cmd_ready = 1'b0; rsp_valid = 1'b1; rsp_y = 8'h11;
    cycles(1);
    rsp_valid = 1'b0;
    check("bp_result", 16'(result), 16'h11);
    btn = 1'b0;
    cycles(10);

    // Clean press: command appears at edge 7 and transfers at edge 8.
    sw = 16'hA500; btn = 1'b1; cmd_ready = 1'b1;
    cycles(6);
    check("clean_valid_e6", 16'(cmd_valid), 16'h0);
    cycles(1);
    check("clean_valid_e7", 16'(cmd_valid), 16'h1);
    check("clean_op", 16'(cmd_op), 16'h0);
    check("clean_data", 16'(cmd_data), 16'hA5);
    check("clean_busy", 16'(busy), 16'h1);
    cycles(1);
    check("clean_valid_e8", 16'(cmd_valid), 16'h0);
    cycles(1);
    rsp_valid = 1'b1; rsp_y = 8'h3C;
    cycles(1);
    rsp_valid = 1'b0;
    check("clean_result", 16'(result), 16'h3C);
    check("clean_busy_done", 16'(busy), 16'h0);
    check("clean_dropped", 16'(dropped), 16'h0);
    cycles(2);
    btn = 1'b0;
    cycles(10);

    // Press while busy: second press is dropped, flag is sticky.
    sw = 16'h0101; btn = 1'b1; cmd_ready = 1'b1;
    cycles(8);
    check("busy_wait", 16'(busy), 16'h1);
    cmd_ready = 1'b0; btn = 1'b0;
    cycles(8);
    btn = 1'b1;
    cycles(10);
    check("busy_dropped", 16'(dropped), 16'h1);
    check("busy_no_valid", 16'(cmd_valid), 16'h0);
    btn = 1'b0;
    cycles(1);
    rsp_valid = 1'b1; rsp_y = 8'h3C;
    cycles(1);
    rsp_valid = 1'b0;
    check("busy_done", 16'(busy), 16'h0);
    check("busy_dropped_sticky", 16'(dropped), 16'h1);
    cycles(10);

    // Non-result opcode with same-cycle ready and response.
    sw = 16'h000F; btn = 1'b1; cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_y = 8'h99;
    cycles(7);
    check("opf_valid", 16'(cmd_valid), 16'h1);
    check("opf_op", 16'(cmd_op), 16'hF);
    cycles(1);
    check("opf_valid_low", 16'(cmd_valid), 16'h0);
    check("opf_busy", 16'(busy), 16'h0);
    check("opf_result", 16'(result), 16'h3C);
    rsp_valid = 1'b0; btn = 1'b0;
    cycles(10);

    // Asynchronous reset while waiting for the response.
    sw = 16'h2203; btn = 1'b1; cmd_ready = 1'b1;
    cycles(8);
    check("mid_busy", 16'(busy), 16'h1);
    #1 reset = 1'b1;
    #1 check_zero("mid_async");
    cycles(1);
    btn = 1'b0; cmd_ready = 1'b0;
    reset = 1'b0;
    cycles(3);
    check_zero("mid_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Front-end command issuer for the ALU. Synchronises and debounces the "send operation" button, snapshots the opcode/data switches on each clean press, and issues exactly one command per press over a valid/ready handshake. It then waits for the ALU core's response and latches the result byte for the seven-segment display path. It sits between the board pins (`sw`, `btnC`) and the ALU core, and is the initiator side of the core's command interface.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive cycles a synchronised button level must differ from the debounced level before the debounced level flips. This is 1 ms at 100 MHz. Minimum 1.
- `clock`  in  1  board clock, rising-edge.
- `reset`  in  1  reset; one clock, reset is asynchronous and active-high.
- `sw`  in  16  switches: [15:8] data byte, [3:0] opcode, [7:4] unused.
- `btn`  in  1  raw, bouncy send button; asynchronous to `clock`.
- `cmd_valid`  out  1  command offered to ALU core.
- `cmd_op`  out  4  opcode of offered command.
- `cmd_data`  out  8  data byte of offered command.
- `cmd_ready`  in  1  core accepts command this cycle.
- `rsp_valid`  in  1  core result valid this cycle.
- `rsp_y`  in  8  core result Y.
- `result`  out  8  last captured Y, feeds display.
- `busy`  out  1  high whenever state is not IDLE.
- `dropped`  out  1  sticky: a press arrived while busy.

## Operation
- Sync: `btn` and `sw` each pass through 2-flop synchronisers. `sw` is only meaningful at capture.
- Debounce counter:
  - Clears whenever synced btn equals the debounced level.
  - Otherwise increments.
  - On the cycle it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Width is ceil(log2(DEBOUNCE_CYCLES+1)). The counter never wraps.
- Press is a one-cycle pulse on the debounced rising edge (debounced high, delayed copy low). The falling edge produces nothing. A second press requires a debounced release first.
- FSM states: IDLE, ISSUE, WAIT_RSP.
  - IDLE: on press, load `cmd_op`<=sw_sync[3:0] and `cmd_data`<=sw_sync[15:8], set `cmd_valid`, go to ISSUE.
  - ISSUE: hold `cmd_valid`, `cmd_op` and `cmd_data` unchanged until `cmd_ready`=1 at an edge. At that edge clear `cmd_valid` and go to WAIT_RSP. If `rsp_valid` is also 1 at that edge, apply the capture rule and go directly to IDLE.
  - WAIT_RSP: on `rsp_valid`=1, apply the capture rule and go to IDLE.
- Capture rule:
  - Opcodes 0000–1100: `result`<=`rsp_y`.
  - Opcodes 1101–1111 (store Y to A, swap A/B, load data to A): `result` is unchanged. The handshake still completes.
- `rsp_valid` in IDLE, or in ISSUE without `cmd_ready`, is ignored.
- A press in ISSUE or WAIT_RSP is discarded and sets `dropped`=1. `dropped` clears only on reset.
- `cmd_op` and `cmd_data` keep their last values after completion. They are meaningful only while `cmd_valid`=1.

## Timing
- Reset values: `cmd_valid`=0, `cmd_op`=0, `cmd_data`=0, `result`=0, `busy`=0, `dropped`=0. Synchronisers, debounced level, debounce counter and edge delay are all 0. State is IDLE.
- Assertion of `reset` clears all of the above immediately, without waiting for a clock edge, including mid-handshake. The in-flight command is abandoned and the core sees `cmd_valid` fall.
- Press latency, with `btn` held high from the first edge that samples it high (edge 1):
  - Edges 1–2: synchroniser.
  - Edges 3..D+2: debounce count; the debounced level rises at edge D+2.
  - Edge D+3: `cmd_valid`=1 and `busy`=1.
  - D = DEBOUNCE_CYCLES.
- The switch snapshot is sw_sync at edge D+3, i.e. `sw` as sampled two edges earlier.
- Handshake transfer occurs at the edge where `cmd_valid`&`cmd_ready`. `cmd_valid` is low from that edge on.
- Minimum command duration is 1 cycle in ISSUE when the core is combinational-ready and responds in the same cycle. `busy` then falls at the edge after `cmd_valid` rises.
- `result` updates at the response edge. `busy` falls at that same edge.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold `reset` for 3 cycles with `btn` toggling -> all outputs 0 throughout. Deassert with `btn`=0 -> outputs stay 0.
- Clean press: `sw`=16'hA500, `btn` high for 12 cycles, `cmd_ready`=1 -> `cmd_valid` high exactly at edge 7 for 1 cycle with `cmd_op`=0 and `cmd_data`=8'hA5. `rsp_valid` with `rsp_y`=8'h3C two cycles later -> `result`=8'h3C, `busy`=0, `dropped`=0.
- Bounce rejection: `btn` toggles every 2 cycles for 20 cycles, then 0 -> no `cmd_valid`, debounced level stays 0.
- Backpressure: press with `sw`=16'h0F07. `cmd_ready`=0 for 6 cycles while `sw` changes to 16'hFFFF -> `cmd_op` stays 4'h7 and `cmd_data` stays 8'h0F while valid. Transfer on the first `cmd_ready`=1.
- Press while busy: a second clean press (release, then re-press) during WAIT_RSP -> `dropped`=1, no second `cmd_valid`. `dropped` stays 1 after the response.
- Non-result op and reset mid-op: opcode 4'hF, `rsp_y`=8'h99 -> `result` keeps its prior value 8'h3C. Next command: assert `reset` in WAIT_RSP -> `busy`, `cmd_valid` and `result` become 0 before the next clock edge.
